// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB bus bundle for apb_cmd_master.
// The master modport is the block's view; the slave modport is the command source plus APB slave side.
interface apb_cmd_master_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: command -> SETUP/ACCESS, one-cycle registered response 3 cycles after handshake
// (+1 per wait state, capped by TIMEOUT). cmd_ready only in IDLE; the response pulse has no backpressure.
module apb_cmd_master #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             preset,
    apb_cmd_master_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [AW-1:0] r_paddr;
    logic          r_pwrite;
    logic [DW-1:0] r_pwdata;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic          r_rsp_err, w_rsp_err_nxt;
    logic          r_rsp_timeout, w_rsp_timeout_nxt;
    logic          w_cmd_hs;

    assign w_cmd_hs = (r_state == S_IDLE) && bus.cmd_valid;

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_rdata_nxt   = '0;
        w_rsp_err_nxt     = 1'b0;
        w_rsp_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_state_nxt = (bus.cmd_addr[1:0] != 2'b00) ? S_ERR : S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt    = S_ACCESS;
                w_wait_cnt_nxt = '0;
            end
            S_ACCESS: begin
                // pready in the last allowed cycle still completes normally
                if (bus.pready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = bus.pslverr;
                    w_rsp_rdata_nxt = (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_state_nxt       = S_IDLE;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            S_ERR: begin
                w_state_nxt     = S_IDLE;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            // Bus address/control only move on a handshake, so they hold while idle
            if (w_cmd_hs) begin
                r_paddr  <= bus.cmd_addr;
                r_pwrite <= bus.cmd_write;
                r_pwdata <= bus.cmd_wdata;
            end
        end
    end

    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.psel        = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign bus.penable     = (r_state == S_ACCESS);
    assign bus.paddr       = r_paddr;
    assign bus.pwrite      = r_pwrite;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: behavioural APB slave with programmable wait/error, plus a transaction-level
// reference model (word memory, expected latency and response) checked with immediate assertions.
module tb_apb_cmd_master;
    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_cmd_master_if #(.DW(DW), .AW(AW)) bus ();

    apb_cmd_master #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .pclk   (clk),
        .preset (rst),
        .bus    (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // APB slave: stalls slv_wait ACCESS cycles, then completes, optionally with pslverr
    logic [DW-1:0] slv_mem [8];
    bit            slv_mem_init = 1'b0;
    int            slv_wait = 0;
    bit            slv_err  = 1'b0;
    int            acc_cnt  = 0;

    assign bus.pready  = bus.psel && bus.penable && (acc_cnt >= slv_wait);
    assign bus.pslverr = bus.pready && slv_err;
    assign bus.prdata  = bus.pready ? slv_mem[bus.paddr[4:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!slv_mem_init) begin
            for (int i = 0; i < 8; i++) slv_mem[i] <= '0;
            slv_mem_init <= 1'b1;
        end else if (bus.pready && bus.pwrite && !slv_err) begin
            slv_mem[bus.paddr[4:2]] <= bus.pwdata;
        end
        acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
    end

    logic [DW-1:0] ref_mem [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from a negedge; returns at the negedge of the response cycle.
    task automatic do_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int w, input bit err, input bit chain, output time hs_t);
        bit            aligned;
        bit            exp_err, exp_to;
        logic [DW-1:0] exp_rd;
        int            exp_lat, exp_acc, exp_sel;
        int            cyc, n_sel, n_acc;
        bit            got, stable, busy_ok;

        aligned = (addr[1:0] == 2'b00);
        exp_rd  = '0;
        exp_to  = 1'b0;
        if (!aligned) begin
            exp_err = 1'b1; exp_lat = 2; exp_acc = 0;
        end else if (w >= TIMEOUT) begin
            exp_err = 1'b1; exp_to = 1'b1; exp_lat = TIMEOUT + 2; exp_acc = TIMEOUT;
        end else begin
            exp_err = err; exp_lat = w + 3; exp_acc = w + 1;
            if (!wr && !err) exp_rd = ref_mem[addr[4:2]];
            if (wr && !err) ref_mem[addr[4:2]] = wdata;
        end
        exp_sel = aligned ? exp_acc + 1 : 0;

        slv_wait = w;
        slv_err  = err;
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(posedge clk);
        hs_t = $time;
        @(negedge clk);
        check("psel_first", 64'(bus.psel), 64'(aligned));
        check("penable_first", 64'(bus.penable), 64'd0);

        cyc = 1; got = 1'b0; stable = 1'b1; busy_ok = 1'b1; n_sel = 0; n_acc = 0;
        while (!got && cyc < 60) begin
            // Garbage on the command side while busy must be ignored
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = AW'($urandom);
            bus.cmd_wdata = $urandom;
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else begin
                if (bus.cmd_ready) busy_ok = 1'b0;
                if (bus.psel) begin
                    n_sel++;
                    if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata) stable = 1'b0;
                end
                if (bus.penable) begin
                    n_acc++;
                    if (!bus.psel) stable = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        check("rsp_seen", 64'(got), 64'd1);
        check("rsp_latency", 64'(cyc), 64'(exp_lat));
        check("psel_cycles", 64'(n_sel), 64'(exp_sel));
        check("access_cycles", 64'(n_acc), 64'(exp_acc));
        check("bus_stable", 64'(stable), 64'd1);
        check("not_ready_busy", 64'(busy_ok), 64'd1);
        check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        check("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        check("psel_at_rsp", 64'(bus.psel), 64'd0);
        check("ready_at_rsp", 64'(bus.cmd_ready), 64'd1);
        if (!chain) bus.cmd_valid = 1'b0;
    endtask

    initial begin
        time t0, t1, t2;
        bit  no_rsp;
        bit            r_wr, r_err, r_chain;
        logic [AW-1:0] r_addr;
        int            r_w, r_sel;

        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_psel", 64'(bus.psel), 64'd0);
        check("rst_penable", 64'(bus.penable), 64'd0);
        check("rst_pwrite", 64'(bus.pwrite), 64'd0);
        check("rst_paddr", 64'(bus.paddr), 64'd0);
        check("rst_pwdata", 64'(bus.pwdata), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Zero-wait write then read
        do_cmd(1'b1, 5'h04, 32'hDEADBEEF, 0, 1'b0, 1'b0, t0);
        do_cmd(1'b0, 5'h04, 32'h0, 0, 1'b0, 1'b0, t0);

        // Back-to-back writes with valid held high
        do_cmd(1'b1, 5'h00, 32'h1111_0000, 0, 1'b0, 1'b1, t0);
        do_cmd(1'b1, 5'h08, 32'h2222_0008, 0, 1'b0, 1'b1, t1);
        do_cmd(1'b1, 5'h0C, 32'h3333_000C, 0, 1'b0, 1'b0, t2);
        check("btb_gap_1", 64'(t1 - t0), 64'd30);
        check("btb_gap_2", 64'(t2 - t1), 64'd30);
        do_cmd(1'b0, 5'h00, 32'h0, 0, 1'b0, 1'b0, t0);
        do_cmd(1'b0, 5'h08, 32'h0, 0, 1'b0, 1'b0, t0);
        do_cmd(1'b0, 5'h0C, 32'h0, 0, 1'b0, 1'b0, t0);
        do_cmd(1'b0, 5'h04, 32'h0, 0, 1'b0, 1'b0, t0);

        // Wait states
        do_cmd(1'b1, 5'h10, 32'h1234_5678, 0, 1'b0, 1'b0, t0);
        do_cmd(1'b0, 5'h10, 32'hA5A5_A5A5, 5, 1'b0, 1'b0, t0);

        // Timeout, then pready in the final allowed cycle
        do_cmd(1'b0, 5'h00, 32'h0, TIMEOUT + 4, 1'b0, 1'b0, t0);
        do_cmd(1'b0, 5'h10, 32'h0, TIMEOUT - 1, 1'b0, 1'b0, t0);

        // Misaligned, slave errors
        do_cmd(1'b0, 5'h06, 32'h0, 0, 1'b0, 1'b0, t0);
        do_cmd(1'b0, 5'h08, 32'h0, 0, 1'b1, 1'b0, t0);
        do_cmd(1'b1, 5'h08, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, t0);
        do_cmd(1'b0, 5'h08, 32'h0, 0, 1'b0, 1'b0, t0);

        // Reset while the slave stalls in ACCESS
        slv_wait = 1000;
        slv_err  = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 5'h00;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_penable", 64'(bus.penable), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_psel", 64'(bus.psel), 64'd0);
        check("mid_rst_penable", 64'(bus.penable), 64'd0);
        check("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        no_rsp = (bus.rsp_valid == 1'b0);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rsp_valid) no_rsp = 1'b0;
        end
        check("mid_rst_no_rsp", 64'(no_rsp), 64'd1);
        do_cmd(1'b0, 5'h00, 32'h0, 0, 1'b0, 1'b0, t0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            r_wr   = 1'($urandom);
            r_addr = AW'($urandom);
            if ($urandom_range(3) != 0) r_addr[1:0] = 2'b00;
            r_sel = $urandom_range(7);
            if (r_sel == 7)      r_w = TIMEOUT + 2;
            else if (r_sel == 6) r_w = TIMEOUT - 1;
            else                 r_w = $urandom_range(3);
            r_err   = ($urandom_range(7) == 0);
            r_chain = 1'($urandom);
            do_cmd(r_wr, r_addr, $urandom, r_w, r_err, r_chain, t0);
        end
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("final_idle_psel", 64'(bus.psel), 64'd0);
        check("final_rsp_valid", 64'(bus.rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
